// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter and sequencer for a single-port word memory.
// Each access runs IDLE -> ACCESS (gnt, memory strobe) -> RESP (rvalid), one per 3 cycles.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   rN_req/we/addr/wdata     requester N access request (held until rN_gnt)
//   rN_gnt                   one-cycle pulse while requester N's access is in ACCESS
//   rN_rvalid, rN_rdata      completion pulse and registered read data for requester N
//   mem_addr, mem_read       memory read address / read enable
//   mem_write_addr, mem_datai, mem_we   memory write address / data / enable
//   mem_datao                memory read data, combinational from mem_addr when mem_read=1
module mem_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 129
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] mem_write_addr,
    output logic [DATA_W-1:0] mem_datai,
    output logic              mem_we,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_datao
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t state;
    logic   last;     // owner of the most recent grant
    logic   owner;    // owner of the access in flight
    logic   cur_we;
    logic   cur_oor;  // latched address is outside 0..DEPTH-1

    logic              pick1;
    logic              sel_we;
    logic              sel_inr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [DATA_W-1:0] rd_word;

    // On a tie the requester that was not granted last wins.
    always_comb begin
        pick1     = r1_req & (~r0_req | ~last);
        sel_we    = pick1 ? r1_we    : r0_we;
        sel_addr  = pick1 ? r1_addr  : r0_addr;
        sel_wdata = pick1 ? r1_wdata : r0_wdata;
        sel_inr   = (32'(sel_addr) < DEPTH);
        rd_word   = cur_oor ? '0 : mem_datao;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            last           <= 1'b1;
            owner          <= 1'b0;
            cur_we         <= 1'b0;
            cur_oor        <= 1'b0;
            r0_gnt         <= 1'b0;
            r1_gnt         <= 1'b0;
            r0_rvalid      <= 1'b0;
            r1_rvalid      <= 1'b0;
            r0_rdata       <= '0;
            r1_rdata       <= '0;
            mem_addr       <= '0;
            mem_write_addr <= '0;
            mem_datai      <= '0;
            mem_we         <= 1'b0;
            mem_read       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (r0_req || r1_req) begin
                        owner          <= pick1;
                        last           <= pick1;
                        cur_we         <= sel_we;
                        cur_oor        <= ~sel_inr;
                        mem_addr       <= sel_addr;
                        mem_write_addr <= sel_addr;
                        mem_datai      <= sel_wdata;
                        // Strobes are registered so they are high for exactly the ACCESS cycle;
                        // out-of-range accesses get no strobe at all.
                        mem_we         <= sel_we & sel_inr;
                        mem_read       <= ~sel_we & sel_inr;
                        r0_gnt         <= ~pick1;
                        r1_gnt         <= pick1;
                        state          <= ACCESS;
                    end
                end
                ACCESS: begin
                    r0_gnt   <= 1'b0;
                    r1_gnt   <= 1'b0;
                    mem_we   <= 1'b0;
                    mem_read <= 1'b0;
                    if (!cur_we) begin
                        if (owner) r1_rdata <= rd_word;
                        else       r0_rdata <= rd_word;
                    end
                    r0_rvalid <= ~owner;
                    r1_rvalid <= owner;
                    state     <= RESP;
                end
                RESP: begin
                    r0_rvalid <= 1'b0;
                    r1_rvalid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
